// File: rtl/apb_req_arbiter_pkg.sv
// apb_arb_pkg: FSM state encoding, index-width helper and default timeout shared by apb_req_arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b10, ACCESS = 2'b11} state_e;
  localparam int TIMEOUT_CYC_DEF = 16;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester-side handshake and APB bus signals; master = arbiter view, slave = requesters/APB slave view
interface apb_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic rsp_err;
  logic psel;
  logic penable;
  logic [AW-1:0] paddr;
  logic pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic pready;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_req_arbiter_rr.sv
// apb_rr_arbiter: one-hot rotate-priority pick of the first valid requester at or after the pointer
module apb_rr_arbiter import apb_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the requester closest to the pointer wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % NREQ);
      if (valid_i[j]) begin
        gnt_o = NREQ'(1) << j;
        idx_o = j;
      end
    end
  end
  assign any_o = |valid_i;
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master front-end for NREQ requesters; APB_ARB_TIMEOUT_EN adds an ACCESS wait-state timeout abort
module apb_req_arbiter import apb_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic pclk,
  input logic preset,
  apb_req_arbiter_if.master bus
);
  localparam int IW = idx_w(NREQ);
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("apb_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 2");
  end
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, g_q, pick_idx;
  logic [NREQ-1:0] cand, pick, rsp_valid_q;
  logic arb_pt, accept, done, abort, any;
  logic [AW-1:0] paddr_q;
  logic pwrite_q;
  logic [DW-1:0] pwdata_q, rsp_rdata_q;
  // The requester whose transfer is on the bus cannot win again before its response
  assign cand = bus.req_valid & ~((state_q == IDLE) ? {NREQ{1'b0}} : (NREQ'(1) << g_q));
  apb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .valid_i(cand),
    .ptr_i(ptr_q),
    .gnt_o(pick),
    .idx_o(pick_idx),
    .any_o(any)
  );
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] cnt_q;
  logic rsp_err_q;
  assign abort = state_q == ACCESS && !bus.pready && cnt_q == CW'(TIMEOUT_CYC - 1);
  assign bus.rsp_err = rsp_err_q;
  // Wait-state counter is zero on ACCESS entry and counts pready-low cycles
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ACCESS && !bus.pready) ? cnt_q + 1'b1 : '0;
      rsp_err_q <= abort;
    end
`else
  assign abort = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  // Arbitration points are IDLE or a completing ACCESS; a pending request skips the IDLE bubble
  always_comb begin
    arb_pt = state_q == IDLE || (state_q == ACCESS && bus.pready);
    accept = arb_pt && any;
    done = state_q == ACCESS && (bus.pready || abort);
    state_d = accept ? SETUP : (state_q == SETUP) ? ACCESS : (state_q == ACCESS && !done) ? ACCESS : IDLE;
  end
  assign bus.req_ready = accept ? pick : '0;
  assign bus.psel = state_q != IDLE;
  assign bus.penable = state_q == ACCESS;
  assign bus.paddr = paddr_q;
  assign bus.pwrite = pwrite_q;
  assign bus.pwdata = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  // State, pointer, captured payload and registered response
  always_ff @(posedge pclk or negedge preset)
    if (!preset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        g_q <= pick_idx;
        ptr_q <= IW'((int'(pick_idx) + 1) % NREQ);
        paddr_q <= bus.req_addr[pick_idx*AW +: AW];
        pwrite_q <= bus.req_write[pick_idx];
        pwdata_q <= bus.req_wdata[pick_idx*DW +: DW];
      end
      rsp_valid_q <= done ? NREQ'(1) << g_q : '0;
      if (abort) rsp_rdata_q <= '0;
      else if (done && !pwrite_q) rsp_rdata_q <= bus.prdata;
    end
endmodule
